zcrv_regfile_mp: RTL and testbench

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It replaces the single-write, dual-read register file between decode/issue and commit. Issue reserves destination registers, and commit ports write results and release the reservations. Each read port returns data together with a busy flag that the issue stage uses for RAW stalls.

---
 rtl/zcrv_regfile_mp.sv | 91 +++++++++
 tb/tb_zcrv_regfile_mp.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zcrv_regfile_mp.sv
// zcrv_regfile_mp: multi-port integer register file with an integrated busy-bit scoreboard.
// Optional macro ZCRV_RF_BYPASS_EN forwards same-cycle write data to the read ports.
module zcrv_regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int IDXW = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*IDXW-1:0]  rd_index,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*IDXW-1:0]  wr_index,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 alloc_en,
    input  logic [IDXW-1:0]      alloc_index,
    output logic                 alloc_stall,
    output logic [NREG-1:0]      busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] release_vec;
    logic [IDXW-1:0] rd_idx;

    always_comb begin
        release_vec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                release_vec[wr_index[w*IDXW +: IDXW]] = 1'b1;
            end
        end
    end

    // A release of the very register being reserved resolves the WAW hazard this cycle.
    assign alloc_stall = alloc_en & busy[alloc_index] & ~release_vec[alloc_index];
    assign busy_vec    = busy;

    // Release first, then allocate, so a same-cycle allocate leaves the register busy.
    always_comb begin
        busy_next = busy & ~release_vec;
        if (alloc_en && (alloc_index != '0) && !alloc_stall) begin
            busy_next[alloc_index] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            busy <= busy_next;
            // Ascending port order lets the highest-numbered colliding port win.
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_index[w*IDXW +: IDXW] != '0)) begin
                    regs[wr_index[w*IDXW +: IDXW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_idx = rd_index[p*IDXW +: IDXW];
            if (rst_n && rd_en[p] && (rd_idx != '0)) begin
                rd_data[p*XLEN +: XLEN] = regs[rd_idx];
                rd_busy[p]              = busy[rd_idx];
`ifdef ZCRV_RF_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_index[w*IDXW +: IDXW] == rd_idx)) begin
                        rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                        rd_busy[p]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_zcrv_regfile_mp.sv
// tb_zcrv_regfile_mp: directed and randomized checks of zcrv_regfile_mp against an array-based model.
// Expectations follow ZCRV_RF_BYPASS_EN the same way the design does.
module tb_zcrv_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int IDXW = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic                clk;
    logic                rst_n;
    logic [NRD-1:0]      rd_en;
    logic [NRD*IDXW-1:0] rd_index;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*IDXW-1:0] wr_index;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [IDXW-1:0]     alloc_index;
    logic                alloc_stall;
    logic [NREG-1:0]     busy_vec;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    zcrv_regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .IDXW(IDXW), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_index(alloc_index), .alloc_stall(alloc_stall),
        .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rd_en = '0; rd_index = '0;
        wr_en = '0; wr_index = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_index = '0;
    endtask

    task automatic set_rd(input int p, input int idx);
        rd_en[p] = 1'b1;
        rd_index[p*IDXW +: IDXW] = IDXW'(idx);
    endtask

    task automatic set_wr(input int w, input int idx, input logic [XLEN-1:0] d);
        wr_en[w] = 1'b1;
        wr_index[w*IDXW +: IDXW] = IDXW'(idx);
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_alloc(input int idx);
        alloc_en = 1'b1;
        alloc_index = IDXW'(idx);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Expected read data from the architectural view, with forwarding when enabled.
    function automatic logic [XLEN-1:0] exp_data(input int p);
        int idx;
        logic [XLEN-1:0] d;
        idx = int'(rd_index[p*IDXW +: IDXW]);
        if (!rst_n || !rd_en[p] || idx == 0) return '0;
        d = m_regs[idx];
`ifdef ZCRV_RF_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_index[w*IDXW +: IDXW]) == idx) d = wr_data[w*XLEN +: XLEN];
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input int p);
        int idx;
        logic b;
        idx = int'(rd_index[p*IDXW +: IDXW]);
        if (!rst_n || !rd_en[p] || idx == 0) return 1'b0;
        b = m_busy[idx];
`ifdef ZCRV_RF_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_index[w*IDXW +: IDXW]) == idx) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic exp_stall();
        int ai;
        ai = int'(alloc_index);
        if (!alloc_en || !m_busy[ai]) return 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_index[w*IDXW +: IDXW]) == ai) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NREG-1:0] exp_busy_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Advance one clock: apply writes, then reservations, to the model; inputs return to idle.
    task automatic tick();
        logic [XLEN-1:0] nr [NREG];
        bit              nb [NREG];
        bit              stall;
        int              idx;
        nr = m_regs;
        nb = m_busy;
        stall = exp_stall();
        for (int w = 0; w < NWR; w++) begin
            idx = int'(wr_index[w*IDXW +: IDXW]);
            if (wr_en[w] && idx != 0) begin
                nr[idx] = wr_data[w*XLEN +: XLEN];
                nb[idx] = 1'b0;
            end
        end
        if (alloc_en && alloc_index != '0 && !stall) nb[int'(alloc_index)] = 1'b1;
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_regs = nr;
            m_busy = nb;
        end
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NREG; i++) begin
            set_rd(0, i);
            set_rd(1, NREG - 1 - i);
            set_alloc(i);
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*XLEN +: XLEN] !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset_rd_data port%0d idx%0d: got %h expected 0", p, i, rd_data[p*XLEN +: XLEN]);
                end
                checks++;
                if (rd_busy[p] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_rd_busy port%0d idx%0d: got %b expected 0", p, i, rd_busy[p]);
                end
            end
            checks++;
            if (busy_vec !== '0 || alloc_stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy_vec: got %h/%b expected 0/0", busy_vec, alloc_stall);
            end
        end
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alloc_write();
        set_alloc(5);
        #1;
        checks++;
        if (alloc_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alloc5_stall: got %b expected 0", alloc_stall);
        end
        tick();
        set_rd(0, 5);
        set_rd(1, 5);
        #1;
        checks++;
        if (rd_busy !== 2'b11 || busy_vec[5] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alloc5_busy: got rd_busy=%b busy_vec[5]=%b expected 11/1", rd_busy, busy_vec[5]);
        end
        set_wr(0, 5, 32'hDEADBEEF);
        #1;
        checks++;
`ifdef ZCRV_RF_BYPASS_EN
        if (rd_data[XLEN-1:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
`else
        if (rd_data[XLEN-1:0] !== 32'h0 || rd_busy[0] !== 1'b1) begin
`endif
            errors++;
            $display("[TB] FAIL wr5_same_cycle: got %h busy=%b", rd_data[XLEN-1:0], rd_busy[0]);
        end
        tick();
        set_rd(1, 5);
        #1;
        checks++;
        if (rd_data[2*XLEN-1:XLEN] !== 32'hDEADBEEF || rd_busy[1] !== 1'b0 || busy_vec[5] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr5_next_cycle: got %h busy=%b expected deadbeef/0", rd_data[2*XLEN-1:XLEN], rd_busy[1]);
        end
    endtask

    task automatic test_collision();
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        tick();
        set_rd(0, 7);
        #1;
        checks++;
        if (rd_data[XLEN-1:0] !== 32'h22) begin
            errors++;
            $display("[TB] FAIL collision_x7: got %h expected 00000022", rd_data[XLEN-1:0]);
        end
    endtask

    task automatic test_x0();
        set_wr(1, 0, 32'hFFFFFFFF);
        set_alloc(0);
        #1;
        checks++;
        if (alloc_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_stall: got %b expected 0", alloc_stall);
        end
        tick();
        set_rd(0, 0);
        rd_en[1] = 1'b0;
        rd_index[2*IDXW-1:IDXW] = 5'd7;
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_vec[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_read: got data=%h busy=%b bv0=%b expected 0", rd_data, rd_busy, busy_vec[0]);
        end
    endtask

    task automatic test_waw();
        set_alloc(9);
        tick();
        set_alloc(9);
        #1;
        checks++;
        if (alloc_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL waw_stall: got %b expected 1", alloc_stall);
        end
        tick();
        set_alloc(9);
        set_wr(1, 9, 32'h99);
        #1;
        checks++;
        if (alloc_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL waw_release_stall: got %b expected 0", alloc_stall);
        end
        tick();
        set_rd(0, 9);
        #1;
        checks++;
        if (busy_vec[9] !== 1'b1 || rd_busy[0] !== 1'b1 || rd_data[XLEN-1:0] !== 32'h99) begin
            errors++;
            $display("[TB] FAIL waw_realloc: got bv9=%b busy=%b data=%h expected 1/1/00000099", busy_vec[9], rd_busy[0], rd_data[XLEN-1:0]);
        end
    endtask

    task automatic test_bypass();
        set_wr(0, 3, 32'hAAAA);
        tick();
        set_rd(1, 3);
        set_wr(1, 3, 32'h1234);
        #1;
        checks++;
`ifdef ZCRV_RF_BYPASS_EN
        if (rd_data[2*XLEN-1:XLEN] !== 32'h1234) begin
`else
        if (rd_data[2*XLEN-1:XLEN] !== 32'hAAAA) begin
`endif
            errors++;
            $display("[TB] FAIL x3_same_cycle: got %h", rd_data[2*XLEN-1:XLEN]);
        end
        tick();
        set_rd(1, 3);
        #1;
        checks++;
        if (rd_data[2*XLEN-1:XLEN] !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL x3_next_cycle: got %h expected 00001234", rd_data[2*XLEN-1:XLEN]);
        end
    endtask

    function automatic int rand_idx();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1)) : int'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int p = 0; p < NRD; p++)
                if ($urandom_range(0, 4) != 0) set_rd(p, rand_idx());
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 2) == 0) set_wr(w, rand_idx(), $urandom);
            if ($urandom_range(0, 1) == 0) set_alloc(rand_idx());
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*XLEN +: XLEN] !== exp_data(p) || rd_busy[p] !== exp_busy(p)) begin
                    errors++;
                    $display("[TB] FAIL rand_read n%0d port%0d: got %h/%b expected %h/%b", n, p,
                             rd_data[p*XLEN +: XLEN], rd_busy[p], exp_data(p), exp_busy(p));
                end
            end
            checks++;
            if (alloc_stall !== exp_stall() || busy_vec !== exp_busy_vec()) begin
                errors++;
                $display("[TB] FAIL rand_sb n%0d: got stall=%b bv=%h expected %b/%h", n,
                         alloc_stall, busy_vec, exp_stall(), exp_busy_vec());
            end
            tick();
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_alloc_write();
        test_collision();
        test_x0();
        test_waw();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
